// File: rtl/blocking_sa_cache.sv
// Blocking, write-back, write-allocate set-associative data cache.
// One request in flight; misses write back a dirty victim block over DMA,
// fill the missing block, then replay the lookup, which then hits.
module blocking_sa_cache #(
  parameter int addr_width_p          = 32,
  parameter int data_width_p          = 32,
  parameter int block_size_in_words_p = 4,
  parameter int sets_p                = 4,
  parameter int ways_p                = 2
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [2+addr_width_p+data_width_p-1:0] cache_pkt_i,
  input  logic                                   v_i,
  output logic                                   ready_o,
  output logic [data_width_p-1:0]                data_o,
  output logic                                   v_o,
  input  logic                                   yumi_i,
  output logic [addr_width_p:0]                  dma_pkt_o,
  output logic                                   dma_pkt_v_o,
  input  logic                                   dma_pkt_yumi_i,
  input  logic [data_width_p-1:0]                dma_data_i,
  input  logic                                   dma_data_v_i,
  output logic                                   dma_data_ready_o,
  output logic [data_width_p-1:0]                dma_data_o,
  output logic                                   dma_data_v_o,
  input  logic                                   dma_data_yumi_i,
  output logic                                   v_we_o
);

  localparam int off_w       = $clog2(data_width_p / 8);
  localparam int blk_w       = $clog2(block_size_in_words_p);
  localparam int idx_w       = $clog2(sets_p);
  localparam int way_w       = $clog2(ways_p);
  localparam int tag_w       = addr_width_p - idx_w - blk_w - off_w;
  localparam int data_addr_w = idx_w + way_w + blk_w;
  localparam int words_p     = sets_p * ways_p * block_size_in_words_p;
  localparam int pkt_w       = 2 + addr_width_p + data_width_p;

  typedef enum logic [1:0] {OP_LW = 2'b00, OP_SW = 2'b01, OP_TAGST = 2'b10, OP_RSVD = 2'b11} opcode_e;
  typedef enum logic [2:0] {IDLE, LOOKUP, WB_REQ, WB_SEND, FILL_REQ, FILL_RECV} state_e;

  state_e                         state, state_next;
  opcode_e                        req_op;
  logic [addr_width_p-1:0]        req_addr;
  logic [data_width_p-1:0]        req_data;

  logic [tag_w-1:0]               tag_mem [sets_p][ways_p];
  logic [data_width_p-1:0]        data_mem [words_p];
  logic [sets_p-1:0][ways_p-1:0]  valid_bits;
  logic [sets_p-1:0][ways_p-1:0]  dirty_bits;
  logic [sets_p-1:0][way_w-1:0]   victim_cnt;
  logic [way_w-1:0]               victim_way;
  logic [blk_w-1:0]               word_cnt;

  logic [idx_w-1:0]               req_idx;
  logic [tag_w-1:0]               req_tag;
  logic [blk_w-1:0]               req_word;
  logic [way_w-1:0]               tagst_way;
  logic                           hit, inv_found, victim_dirty;
  logic [way_w-1:0]               hit_way, inv_way, miss_way;
  logic [data_addr_w-1:0]         hit_addr, stream_addr;
  logic                           accept, miss_go, sw_write, tagst_write, fill_write, fill_last;
  logic                           last_word;
  logic                           unused_addr_bits;

  assign req_idx     = req_addr[off_w+blk_w +: idx_w];
  assign req_tag     = req_addr[addr_width_p-1 -: tag_w];
  assign req_word    = req_addr[off_w +: blk_w];
  assign tagst_way   = req_data[way_w:1];
  assign hit_addr    = {req_idx, hit_way, req_word};
  assign stream_addr = {req_idx, victim_way, word_cnt};
  assign last_word   = (word_cnt == blk_w'(block_size_in_words_p - 1));
  assign unused_addr_bits = ^req_addr[off_w-1:0];

  // Tag match and victim choice for the registered request; lowest way wins.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = ways_p - 1; w >= 0; w--) begin
      if (valid_bits[req_idx][w] && (tag_mem[req_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = way_w'(w);
      end
      if (!valid_bits[req_idx][w]) begin
        inv_found = 1'b1;
        inv_way   = way_w'(w);
      end
    end
    miss_way     = inv_found ? inv_way : victim_cnt[req_idx];
    victim_dirty = valid_bits[req_idx][miss_way] && dirty_bits[req_idx][miss_way];
  end

  // Next-state, handshake outputs and array write strobes; all quiet in reset.
  always_comb begin
    // NOTE: every output and strobe is defaulted before the case, so no path
    // leaves one unassigned and no latch is inferred.
    state_next       = state;
    ready_o          = 1'b0;
    v_o              = 1'b0;
    data_o           = '0;
    dma_pkt_v_o      = 1'b0;
    dma_pkt_o        = '0;
    dma_data_v_o     = 1'b0;
    dma_data_o       = '0;
    dma_data_ready_o = 1'b0;
    v_we_o           = 1'b0;
    accept           = 1'b0;
    miss_go          = 1'b0;
    sw_write         = 1'b0;
    tagst_write      = 1'b0;
    fill_write       = 1'b0;
    fill_last        = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          ready_o = 1'b1;
          accept  = v_i;
          if (v_i) state_next = LOOKUP;
        end
        LOOKUP: begin
          case (req_op)
            OP_LW, OP_SW: begin
              if (hit) begin
                v_o = 1'b1;
                if (req_op == OP_LW) data_o = data_mem[hit_addr];
                if (yumi_i) begin
                  state_next = IDLE;
                  if (req_op == OP_SW) begin
                    sw_write = 1'b1;
                    v_we_o   = 1'b1;
                  end
                end
              end else begin
                miss_go    = 1'b1;
                state_next = victim_dirty ? WB_REQ : FILL_REQ;
              end
            end
            OP_TAGST: begin
              v_o = 1'b1;
              if (yumi_i) begin
                tagst_write = 1'b1;
                state_next  = IDLE;
              end
            end
            default: begin
              v_o = 1'b1;
              if (yumi_i) state_next = IDLE;
            end
          endcase
        end
        WB_REQ: begin
          dma_pkt_v_o = 1'b1;
          dma_pkt_o   = {1'b1, tag_mem[req_idx][victim_way], req_idx, {(blk_w+off_w){1'b0}}};
          if (dma_pkt_yumi_i) state_next = WB_SEND;
        end
        WB_SEND: begin
          dma_data_v_o = 1'b1;
          dma_data_o   = data_mem[stream_addr];
          if (dma_data_yumi_i && last_word) state_next = FILL_REQ;
        end
        FILL_REQ: begin
          dma_pkt_v_o = 1'b1;
          dma_pkt_o   = {1'b0, req_addr[addr_width_p-1:blk_w+off_w], {(blk_w+off_w){1'b0}}};
          if (dma_pkt_yumi_i) state_next = FILL_RECV;
        end
        FILL_RECV: begin
          dma_data_ready_o = 1'b1;
          if (dma_data_v_i) begin
            fill_write = 1'b1;
            if (last_word) begin
              fill_last  = 1'b1;
              state_next = LOOKUP;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Control state, request register and per-line status bits.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state      <= IDLE;
      req_op     <= OP_LW;
      req_addr   <= '0;
      req_data   <= '0;
      valid_bits <= '0;
      dirty_bits <= '0;
      victim_cnt <= '0;
      victim_way <= '0;
      word_cnt   <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        req_op   <= opcode_e'(cache_pkt_i[pkt_w-1 -: 2]);
        req_addr <= cache_pkt_i[data_width_p +: addr_width_p];
        req_data <= cache_pkt_i[data_width_p-1:0];
      end
      if (miss_go) victim_way <= miss_way;
      if ((state == WB_SEND && dma_data_yumi_i) || fill_write) word_cnt <= word_cnt + blk_w'(1);
      if (sw_write) dirty_bits[req_idx][hit_way] <= 1'b1;
      if (tagst_write) begin
        valid_bits[req_idx][tagst_way] <= req_data[0];
        dirty_bits[req_idx][tagst_way] <= 1'b0;
      end
      if (fill_last) begin
        valid_bits[req_idx][victim_way] <= 1'b1;
        dirty_bits[req_idx][victim_way] <= 1'b0;
        victim_cnt[req_idx]             <= victim_cnt[req_idx] + way_w'(1);
      end
    end
  end

  // Tag and data arrays: contents are only meaningful behind a valid bit.
  always_ff @(posedge clk) begin
    // NOTE: the arrays are deliberately not reset; the cleared valid bits
    // already make every stale entry unreachable.
    if (sw_write)    data_mem[hit_addr]               <= req_data;
    if (fill_write)  data_mem[stream_addr]            <= dma_data_i;
    if (tagst_write) tag_mem[req_idx][tagst_way]      <= req_tag;
    if (fill_last)   tag_mem[req_idx][victim_way]     <= req_tag;
  end

endmodule

// File: tb/tb_blocking_sa_cache.sv
// Directed bench for blocking_sa_cache with a block-granular DMA memory
// responder and a flat reference memory for the random load/store mix.
module tb_blocking_sa_cache;

  logic        clk;
  logic        reset;
  logic [65:0] cache_pkt_i;
  logic        v_i;
  logic        ready_o;
  logic [31:0] data_o;
  logic        v_o;
  logic        yumi_i;
  logic [32:0] dma_pkt_o;
  logic        dma_pkt_v_o;
  logic        dma_pkt_yumi_i;
  logic [31:0] dma_data_i;
  logic        dma_data_v_i;
  logic        dma_data_ready_o;
  logic [31:0] dma_data_o;
  logic        dma_data_v_o;
  logic        dma_data_yumi_i;
  logic        v_we_o;

  blocking_sa_cache dut (
    .clk(clk), .reset(reset), .cache_pkt_i(cache_pkt_i), .v_i(v_i), .ready_o(ready_o),
    .data_o(data_o), .v_o(v_o), .yumi_i(yumi_i), .dma_pkt_o(dma_pkt_o),
    .dma_pkt_v_o(dma_pkt_v_o), .dma_pkt_yumi_i(dma_pkt_yumi_i), .dma_data_i(dma_data_i),
    .dma_data_v_i(dma_data_v_i), .dma_data_ready_o(dma_data_ready_o), .dma_data_o(dma_data_o),
    .dma_data_v_o(dma_data_v_o), .dma_data_yumi_i(dma_data_yumi_i), .v_we_o(v_we_o)
  );

  localparam logic [1:0] LW = 2'b00, SW = 2'b01, TAGST = 2'b10, RSVD = 2'b11;

  logic [31:0] dma_mem [1024];
  logic [31:0] ref_mem [1024];
  logic [32:0] pkt_log [$];
  logic [31:0] wb_log  [$];
  int dma_stall_max = 0;
  int dma_errors    = 0;
  int we_count      = 0;
  int n_cmp         = 0;
  int n_bad         = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) if (!reset && v_we_o) we_count <= we_count + 1;

  // DMA memory: accepts command packets, sinks writebacks, sources fills.
  initial begin : dma_responder
    logic [32:0] pkt;
    logic [31:0] a;
    int guard;
    dma_pkt_yumi_i = 1'b0; dma_data_i = '0; dma_data_v_i = 1'b0; dma_data_yumi_i = 1'b0;
    forever begin
      @(negedge clk);
      if (reset || !dma_pkt_v_o) continue;
      repeat ($urandom_range(0, dma_stall_max)) @(negedge clk);
      pkt = dma_pkt_o;
      pkt_log.push_back(pkt);
      if (pkt[31:12] != 0 || pkt[3:0] != 0) dma_errors++;
      dma_pkt_yumi_i = 1'b1; @(posedge clk); #1 dma_pkt_yumi_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
        a = pkt[31:0] + 32'(4 * k);
        guard = 0;
        if (pkt[32]) begin
          do begin @(negedge clk); guard++; end while (!dma_data_v_o && guard < 100);
          if (!dma_data_v_o) begin dma_errors++; break; end
          repeat ($urandom_range(0, dma_stall_max)) @(negedge clk);
          wb_log.push_back(dma_data_o);
          dma_mem[a[11:2]] = dma_data_o;
          dma_data_yumi_i = 1'b1; @(posedge clk); #1 dma_data_yumi_i = 1'b0;
        end else begin
          do begin @(negedge clk); guard++; end while (!dma_data_ready_o && guard < 100);
          if (!dma_data_ready_o) begin dma_errors++; break; end
          repeat ($urandom_range(0, dma_stall_max)) @(negedge clk);
          dma_data_i   = dma_mem[a[11:2]];
          dma_data_v_i = 1'b1; @(posedge clk); #1 dma_data_v_i = 1'b0;
        end
      end
    end
  end

  // Issue one request, wait for its response, consume it; lat counts cycles
  // from the accepting edge to the cycle in which v_o is seen.
  task automatic do_req(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] resp, output int lat, output bit got);
    int guard = 0;
    @(negedge clk);
    cache_pkt_i = {op, addr, wdata};
    v_i = 1'b1;
    while (!ready_o && guard < 1000) begin @(negedge clk); guard++; end
    @(posedge clk); #1 v_i = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!v_o && lat < 2000);
    got = v_o && (guard < 1000);
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL req_timeout op=%0d addr=%h got v_o=%b need 1", op, addr, v_o);
    end
    resp = data_o;
    if (op == SW) ref_mem[addr[11:2]] = wdata;
    yumi_i = 1'b1; @(posedge clk); #1 yumi_i = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({ready_o, v_o, dma_pkt_v_o, dma_data_v_o, dma_data_ready_o, v_we_o} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_outputs got %b need 000000",
               {ready_o, v_o, dma_pkt_v_o, dma_data_v_o, dma_data_ready_o, v_we_o});
    end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ready_o !== 1'b1) begin n_bad++; $display("FAIL idle_ready got %b need 1", ready_o); end
  endtask

  task automatic test_tagst();
    logic [31:0] resp; int lat; bit got;
    for (int s = 0; s < 4; s++) begin
      for (int w = 0; w < 2; w++) begin
        do_req(TAGST, 32'(s) << 4, 32'(w) << 1, resp, lat, got);
        n_cmp++;
        if (resp !== 32'h0) begin n_bad++; $display("FAIL tagst_resp s=%0d w=%0d got %h need 0", s, w, resp); end
        n_cmp++;
        if (lat !== 1) begin n_bad++; $display("FAIL tagst_lat got %0d need 1", lat); end
      end
    end
    n_cmp++;
    if (pkt_log.size() !== 0) begin n_bad++; $display("FAIL tagst_no_dma got %0d pkts need 0", pkt_log.size()); end
  endtask

  task automatic test_cold_miss();
    logic [31:0] resp; int lat; bit got;
    pkt_log.delete(); wb_log.delete();
    do_req(LW, 32'h10, 32'h0, resp, lat, got);
    n_cmp++;
    if (resp !== 32'hC0DE0004) begin n_bad++; $display("FAIL cold_resp got %h need c0de0004", resp); end
    n_cmp++;
    if (lat !== 7) begin n_bad++; $display("FAIL cold_latency got %0d need 7", lat); end
    n_cmp++;
    if (pkt_log.size() != 1 || pkt_log[0] !== {1'b0, 32'h10}) begin
      n_bad++; $display("FAIL cold_pkt got %0d pkts need one read of 0x10", pkt_log.size());
    end
    n_cmp++;
    if (wb_log.size() !== 0) begin n_bad++; $display("FAIL cold_no_wb got %0d words need 0", wb_log.size()); end
    do_req(LW, 32'h10, 32'h0, resp, lat, got);
    n_cmp++;
    if (resp !== 32'hC0DE0004 || lat !== 1) begin
      n_bad++; $display("FAIL rehit got %h lat %0d need c0de0004 lat 1", resp, lat);
    end
    n_cmp++;
    if (pkt_log.size() !== 1) begin n_bad++; $display("FAIL rehit_no_dma got %0d pkts need 1", pkt_log.size()); end
  endtask

  task automatic test_store();
    logic [31:0] resp; int lat; bit got; int w0;
    w0 = we_count;
    do_req(SW, 32'h10, 32'hDEADBEEF, resp, lat, got);
    n_cmp++;
    if (resp !== 32'h0 || lat !== 1) begin n_bad++; $display("FAIL sw_resp got %h lat %0d need 0 lat 1", resp, lat); end
    do_req(LW, 32'h10, 32'h0, resp, lat, got);
    n_cmp++;
    if (resp !== 32'hDEADBEEF) begin n_bad++; $display("FAIL sw_readback got %h need deadbeef", resp); end
    n_cmp++;
    if (we_count - w0 !== 1) begin n_bad++; $display("FAIL we_pulses got %0d need 1", we_count - w0); end
    n_cmp++;
    if (pkt_log.size() !== 1) begin n_bad++; $display("FAIL sw_no_dma got %0d pkts need 1", pkt_log.size()); end
  endtask

  task automatic test_hold();
    @(negedge clk);
    cache_pkt_i = {LW, 32'h10, 32'h0};
    v_i = 1'b1;
    @(posedge clk); #1 v_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({v_o, ready_o, data_o} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
        n_bad++; $display("FAIL hold_c%0d got v=%b rdy=%b d=%h need v=1 rdy=0 d=deadbeef", c, v_o, ready_o, data_o);
      end
    end
    yumi_i = 1'b1; @(posedge clk); #1 yumi_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({v_o, ready_o} !== 2'b01) begin n_bad++; $display("FAIL hold_release got v=%b rdy=%b need v=0 rdy=1", v_o, ready_o); end
  endtask

  task automatic test_writeback();
    logic [31:0] resp; int lat; bit got;
    logic [31:0] exp_wb [4];
    exp_wb[0] = 32'hDEADBEEF; exp_wb[1] = 32'hC0DE0005; exp_wb[2] = 32'hC0DE0006; exp_wb[3] = 32'hC0DE0007;
    pkt_log.delete(); wb_log.delete();
    do_req(LW, 32'h50, 32'h0, resp, lat, got);
    n_cmp++;
    if (resp !== 32'hC0DE0014 || lat !== 7) begin n_bad++; $display("FAIL fill2 got %h lat %0d need c0de0014 lat 7", resp, lat); end
    n_cmp++;
    if (pkt_log.size() != 1 || pkt_log[0] !== {1'b0, 32'h50}) begin
      n_bad++; $display("FAIL fill2_pkt got %0d pkts need one read of 0x50", pkt_log.size());
    end
    pkt_log.delete();
    do_req(LW, 32'h90, 32'h0, resp, lat, got);
    n_cmp++;
    if (resp !== 32'hC0DE0024 || lat !== 12) begin n_bad++; $display("FAIL evict got %h lat %0d need c0de0024 lat 12", resp, lat); end
    n_cmp++;
    if (pkt_log.size() != 2 || pkt_log[0] !== {1'b1, 32'h10} || pkt_log[1] !== {1'b0, 32'h90}) begin
      n_bad++; $display("FAIL evict_pkts got %0d pkts need wb 0x10 then read 0x90", pkt_log.size());
    end
    n_cmp++;
    if (wb_log.size() !== 4) begin n_bad++; $display("FAIL wb_count got %0d need 4", wb_log.size()); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (wb_log.size() != 4 || wb_log[k] !== exp_wb[k]) begin
        n_bad++; $display("FAIL wb_word%0d need %h", k, exp_wb[k]);
      end
    end
    pkt_log.delete(); wb_log.delete();
    do_req(LW, 32'h10, 32'h0, resp, lat, got);
    n_cmp++;
    if (resp !== 32'hDEADBEEF) begin n_bad++; $display("FAIL refetch got %h need deadbeef", resp); end
    n_cmp++;
    if (pkt_log.size() != 1 || pkt_log[0] !== {1'b0, 32'h10} || wb_log.size() != 0) begin
      n_bad++; $display("FAIL refetch_pkts got %0d pkts %0d wb words need one read of 0x10", pkt_log.size(), wb_log.size());
    end
  endtask

  task automatic test_reserved();
    logic [31:0] resp; int lat; bit got;
    pkt_log.delete();
    do_req(RSVD, 32'h10, 32'h12345678, resp, lat, got);
    n_cmp++;
    if (resp !== 32'h0 || lat !== 1) begin n_bad++; $display("FAIL rsvd_resp got %h lat %0d need 0 lat 1", resp, lat); end
    do_req(LW, 32'h10, 32'h0, resp, lat, got);
    n_cmp++;
    if (resp !== 32'hDEADBEEF || lat !== 1 || pkt_log.size() != 0) begin
      n_bad++; $display("FAIL rsvd_no_effect got %h lat %0d pkts %0d need deadbeef lat 1 pkts 0", resp, lat, pkt_log.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] resp; int lat; bit got;
    do_req(LW, 32'h14, 32'h0, resp, lat, got);
    n_cmp++;
    if (resp !== 32'hC0DE0005 || lat !== 1) begin n_bad++; $display("FAIL b2b_lw got %h lat %0d need c0de0005 lat 1", resp, lat); end
    do_req(SW, 32'h18, 32'h11112222, resp, lat, got);
    do_req(LW, 32'h18, 32'h0, resp, lat, got);
    n_cmp++;
    if (resp !== 32'h11112222 || lat !== 1) begin n_bad++; $display("FAIL b2b_sw_lw got %h lat %0d need 11112222 lat 1", resp, lat); end
  endtask

  task automatic test_random();
    logic [31:0] resp, addr, wdata, exp; int lat; bit got; logic [1:0] op;
    int n_req = 0, n_resp = 0;
    dma_stall_max = 2;
    for (int i = 0; i < 80; i++) begin
      op    = ($urandom_range(0, 1) == 0) ? LW : SW;
      addr  = 32'($urandom_range(0, 63)) << 2;
      wdata = $urandom;
      exp   = ref_mem[addr[11:2]];
      do_req(op, addr, wdata, resp, lat, got);
      n_req++;
      if (got) n_resp++;
      if (op == LW) begin
        n_cmp++;
        if (resp !== exp) begin n_bad++; $display("FAIL rand_lw%0d addr=%h got %h need %h", i, addr, resp, exp); end
      end
    end
    dma_stall_max = 0;
    n_cmp++;
    if (n_resp !== n_req) begin n_bad++; $display("FAIL rand_resp_count got %0d need %0d", n_resp, n_req); end
    n_cmp++;
    if (dma_errors !== 0) begin n_bad++; $display("FAIL dma_protocol got %0d errors need 0", dma_errors); end
  endtask

  initial begin
    reset = 1'b1; v_i = 1'b0; yumi_i = 1'b0; cache_pkt_i = '0;
    for (int i = 0; i < 1024; i++) begin
      dma_mem[i] = 32'hC0DE0000 + 32'(i);
      ref_mem[i] = 32'hC0DE0000 + 32'(i);
    end
    test_reset();
    test_tagst();
    test_cold_miss();
    test_store();
    test_hold();
    test_writeback();
    test_reserved();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
